// File: rtl/roulette_game_ctrl.sv
// Roulette game sequencer: start edge + guess -> fast spin, staged slowdown, stop, win/lose verdict.
// Ports: clk, nrst (sync, active-low), start (level, synchronised), guess[2:0] (0..5 valid);
//        seg[5:0] one-hot lit segment, busy (SPIN/DECEL), win/lose (held in RESULT).
module roulette_game_ctrl #(
    parameter int TICK_DIV     = 2500000,
    parameter int SPIN_STEPS   = 24,
    parameter int DECEL_STAGES = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [2:0] guess,
    output logic [5:0] seg,
    output logic       busy,
    output logic       win,
    output logic       lose
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SPIN_STEPS + 6);
    localparam int TW = DECEL_STAGES + 1;

    typedef enum logic [1:0] {IDLE, SPIN, DECEL, RESULT} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   prescaler;
    logic [2:0]      seed_cnt;
    logic            start_q;
    logic [2:0]      guess_r, guess_nxt;
    logic [2:0]      pos, pos_nxt;
    logic [5:0]      seg_r, seg_nxt;
    logic [SW-1:0]   steps_left, steps_nxt;
    logic [TW-1:0]   period, period_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [2:0]      stage, stage_nxt;
    logic            win_r, win_nxt;
    logic            lose_r, lose_nxt;

    logic            tick;
    logic            accept;
    logic            step;
    logic [2:0]      pos_inc;

    assign tick    = (prescaler == PW'(TICK_DIV - 1));
    assign accept  = start & ~start_q & (guess <= 3'd5);
    assign step    = tick && (tcnt == period - TW'(1));
    assign pos_inc = (pos == 3'd5) ? 3'd0 : pos + 3'd1;

    // Free-running prescaler, seed counter and edge-detect flop.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prescaler <= '0;
            seed_cnt  <= '0;
            start_q   <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            seed_cnt  <= (seed_cnt == 3'd5) ? 3'd0 : seed_cnt + 3'd1;
            start_q   <= start;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            guess_r    <= '0;
            pos        <= '0;
            seg_r      <= 6'b000001;
            steps_left <= '0;
            period     <= TW'(1);
            tcnt       <= '0;
            stage      <= '0;
            win_r      <= 1'b0;
            lose_r     <= 1'b0;
        end else begin
            state      <= state_nxt;
            guess_r    <= guess_nxt;
            pos        <= pos_nxt;
            seg_r      <= seg_nxt;
            steps_left <= steps_nxt;
            period     <= period_nxt;
            tcnt       <= tcnt_nxt;
            stage      <= stage_nxt;
            win_r      <= win_nxt;
            lose_r     <= lose_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        guess_nxt  = guess_r;
        pos_nxt    = pos;
        seg_nxt    = seg_r;
        steps_nxt  = steps_left;
        period_nxt = period;
        tcnt_nxt   = tcnt;
        stage_nxt  = stage;
        win_nxt    = win_r;
        lose_nxt   = lose_r;
        case (state)
            IDLE, RESULT: begin
                if (accept) begin
                    state_nxt  = SPIN;
                    guess_nxt  = guess;
                    steps_nxt  = SW'(SPIN_STEPS) + SW'(seed_cnt);
                    period_nxt = TW'(1);
                    tcnt_nxt   = '0;
                    stage_nxt  = '0;
                    win_nxt    = 1'b0;
                    lose_nxt   = 1'b0;
                end
            end
            SPIN, DECEL: begin
                if (step) begin
                    pos_nxt   = pos_inc;
                    seg_nxt   = {seg_r[4:0], seg_r[5]};
                    tcnt_nxt  = '0;
                    steps_nxt = steps_left - SW'(1);
                    // Last step of the current phase (spin or one slowdown stage).
                    if (steps_left == SW'(1)) begin
                        if (state == SPIN) begin
                            state_nxt  = DECEL;
                            stage_nxt  = 3'd1;
                            period_nxt = TW'(2);
                            steps_nxt  = SW'(6);
                        end else if (stage < 3'(DECEL_STAGES)) begin
                            stage_nxt  = stage + 3'd1;
                            period_nxt = period << 1;
                            steps_nxt  = SW'(6);
                        end else begin
                            state_nxt = RESULT;
                            win_nxt   = (pos_inc == guess_r);
                            lose_nxt  = (pos_inc != guess_r);
                        end
                    end
                end else if (tick) begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign seg  = seg_r;
    assign busy = (state == SPIN) || (state == DECEL);
    assign win  = win_r;
    assign lose = lose_r;
endmodule

// File: tb/tb_roulette_game_ctrl.sv
module tb_roulette_game_ctrl;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] guess = 3'd0;
    logic [5:0] seg;
    logic       busy, win, lose;

    int n_checks = 0;
    int n_pass   = 0;
    int ncyc     = 0;
    int exp_pos  = 0;
    bit wrapped  = 1'b0;
    logic [5:0] seen;

    roulette_game_ctrl #(.TICK_DIV(4), .SPIN_STEPS(6), .DECEL_STAGES(2)) dut (
        .clk(clk), .nrst(nrst), .start(start), .guess(guess),
        .seg(seg), .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Non-reset edges since release; equals the expected seed counter value mod 6.
    always @(posedge clk) begin
        if (!nrst) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick_wait();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        nrst = 1'b0; start = 1'b0;
        repeat (3) tick_wait();
        nrst = 1'b1;
    endtask

    // Wait until the next edge samples a seed counter value of s.
    task automatic wait_seed(input int s);
        start = 1'b0;
        tick_wait();
        while (ncyc % 6 != s) tick_wait();
    endtask

    // mode 0: plain game, 1: extra start edges and guess changes while busy, 2: start held high
    task automatic run_game(input logic [2:0] g, input int s, input int mode);
        int rots, cyc, last_t, gap_err, rot_err, wl_err, spin, exp_f, late_busy;
        logic [5:0] prev;
        spin  = 6 + s;
        exp_f = (exp_pos + s) % 6;
        wait_seed(s);
        guess = g; start = 1'b1;
        prev  = seg;
        tick_wait();
        check("accept_busy", busy, 1);
        check("accept_win_clr", win, 0);
        check("accept_lose_clr", lose, 0);
        if (mode != 2) start = 1'b0;
        rots = 0; cyc = 1; last_t = 0; gap_err = 0; rot_err = 0; wl_err = 0;
        while (busy && cyc < 400) begin
            tick_wait();
            cyc++;
            if (seg != prev) begin
                rots++;
                if (seg != {prev[4:0], prev[5]}) rot_err++;
                if (prev == 6'b100000 && seg == 6'b000001) wrapped = 1'b1;
                if (rots > 1 && rots <= spin && cyc - last_t != 4) gap_err++;
                if (rots > spin && rots <= spin + 6 && cyc - last_t != 8) gap_err++;
                if (rots > spin + 6 && cyc - last_t != 16) gap_err++;
                last_t = cyc;
                prev = seg;
            end
            if (busy && (win || lose)) wl_err++;
            if (mode == 1 && busy && cyc % 5 == 0) begin
                start = ~start;
                guess = (g == 3'd5) ? 3'd0 : g + 3'd1;
            end
        end
        if (mode == 1) begin start = 1'b0; guess = g; end
        check("game_done_in_budget", (cyc <= 190) ? 1 : 0, 1);
        check("busy_low_at_end", busy, 0);
        check("rotations", rots, spin + 12);
        check("step_spacing_errs", gap_err, 0);
        check("rotate_left_errs", rot_err, 0);
        check("verdict_while_busy", wl_err, 0);
        check("final_seg", seg, 32'd1 << exp_f);
        check("win", win, (g == exp_f) ? 1 : 0);
        check("lose", lose, (g != exp_f) ? 1 : 0);
        if (mode == 2) begin
            late_busy = 0;
            repeat (20) begin tick_wait(); if (busy) late_busy++; end
            check("held_start_no_regame", late_busy, 0);
            check("held_start_win_kept", win, (g == exp_f) ? 1 : 0);
            start = 1'b0;
        end
        exp_pos = exp_f;
        seen[exp_f] = 1'b1;
    endtask

    initial begin
        int changes, late_busy, rots;
        logic [5:0] prev;

        // Reset values and quiet idle.
        do_reset();
        check("rst_seg", seg, 6'b000001);
        check("rst_busy", busy, 0);
        check("rst_win", win, 0);
        check("rst_lose", lose, 0);
        changes = 0; prev = seg;
        repeat (100) begin tick_wait(); if (seg != prev) changes++; prev = seg; end
        check("idle_seg_stable", changes, 0);

        // Win: guess 3, edge sampled on the 10th cycle after release (seed 3).
        do_reset(); exp_pos = 0;
        repeat (6) tick_wait();
        run_game(3'd3, 3, 0);

        // Lose then replay from RESULT with seed 0, guess 3, extra edges while busy.
        do_reset(); exp_pos = 0;
        repeat (6) tick_wait();
        run_game(3'd2, 3, 0);
        run_game(3'd3, 0, 1);

        // Invalid guess is ignored in RESULT and in IDLE.
        guess = 3'd6; start = 1'b1;
        tick_wait(); tick_wait();
        check("guess6_result_busy", busy, 0);
        check("guess6_result_win_kept", win, 1);
        start = 1'b0;
        do_reset(); exp_pos = 0;
        tick_wait();
        guess = 3'd7; start = 1'b1;
        late_busy = 0;
        repeat (10) begin tick_wait(); if (busy) late_busy++; end
        check("guess_invalid_idle_busy", late_busy, 0);
        start = 1'b0;

        // Start held high through and after a game.
        run_game(3'd1, 1, 2);

        // Reset during the first slowdown stage.
        do_reset(); exp_pos = 0;
        wait_seed(2);
        guess = 3'd0; start = 1'b1;
        tick_wait();
        start = 1'b0;
        rots = 0; prev = seg; changes = 0;
        while (rots < 6 + 2 + 2 && changes < 400) begin
            tick_wait(); changes++;
            if (seg != prev) rots++;
            prev = seg;
        end
        check("midspin_reached_decel", rots, 10);
        nrst = 1'b0;
        tick_wait();
        check("midspin_rst_seg", seg, 6'b000001);
        check("midspin_rst_busy", busy, 0);
        nrst = 1'b1;
        late_busy = 0; changes = 0; prev = seg;
        repeat (60) begin
            tick_wait();
            if (busy) late_busy++;
            if (seg != prev) changes++;
            prev = seg;
        end
        check("midspin_stays_idle", late_busy, 0);
        check("midspin_seg_stable", changes, 0);

        // Six games whose seeds visit every final position.
        do_reset(); exp_pos = 0; seen = '0; wrapped = 1'b0;
        run_game(3'd0, 0, 0);
        run_game(3'd1, 1, 0);
        run_game(3'd5, 4, 0);
        run_game(3'd2, 3, 0);
        run_game(3'd4, 2, 0);
        run_game(3'd3, 5, 0);
        check("all_positions_seen", seen, 6'b111111);
        check("wrap_5_to_0_seen", wrapped, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
